// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events queued in a FWFT FIFO.
// Optional held-key (typematic) filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_sequencer #(
    parameter int  FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             seq_err
);
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t             state_q, state_d;
    logic               seq_err_q, seq_err_d;
    logic               overflow_q, overflow_d;
    logic               key_valid_q, key_valid_d;
    logic [9:0]         head_q, head_d;
    logic [9:0]         mem_q [FIFO_DEPTH];
    logic [9:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dec_push_s, dec_ext_s, dec_brk_s;
    logic               filt_s, push_s, pop_s, full_s, wr_en_s;

    // Prefix decoder: next state, decoded event and error pulse
    always_comb begin
        state_d    = state_q;
        seq_err_d  = 1'b0;
        dec_push_s = 1'b0;
        dec_ext_s  = 1'b0;
        dec_brk_s  = 1'b0;
        if (byte_valid) begin
            if (byte_in == 8'h00 || byte_in == 8'hFF) begin
                seq_err_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_in == 8'hE0)      state_d = S_EXT;
                        else if (byte_in == 8'hF0) state_d = S_BRK;
                        else                       dec_push_s = 1'b1;
                    end
                    S_EXT: begin
                        if (byte_in == 8'hF0)      state_d = S_EXT_BRK;
                        else if (byte_in == 8'hE0) state_d = S_EXT;
                        else begin
                            dec_push_s = 1'b1;
                            dec_ext_s  = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                    S_BRK, S_EXT_BRK: begin
                        state_d = S_IDLE;
                        if (byte_in == 8'hE0 || byte_in == 8'hF0) begin
                            seq_err_d = 1'b1;
                        end else begin
                            dec_push_s = 1'b1;
                            dec_brk_s  = 1'b1;
                            dec_ext_s  = (state_q == S_EXT_BRK);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       rec_valid_q, rec_valid_d;
    logic [8:0] rec_q, rec_d;

    assign filt_s = dec_push_s && !dec_brk_s && rec_valid_q && (rec_q == {dec_ext_s, byte_in});

    // Held-key record: set by a written make, cleared by its matching break
    always_comb begin
        rec_valid_d = rec_valid_q;
        rec_d       = rec_q;
        if (dec_push_s && dec_brk_s && rec_valid_q && (rec_q == {dec_ext_s, byte_in})) begin
            rec_valid_d = 1'b0;
        end else if (wr_en_s && !dec_brk_s) begin
            rec_valid_d = 1'b1;
            rec_d       = {dec_ext_s, byte_in};
        end else begin
            rec_valid_d = rec_valid_q;
        end
    end

    // Record storage
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rec_valid_q <= 1'b0;
            rec_q       <= 9'h000;
        end else begin
            rec_valid_q <= rec_valid_d;
            rec_q       <= rec_d;
        end
    end
`else
    assign filt_s = 1'b0;
`endif

    assign pop_s   = key_valid_q && key_ready;
    assign full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_s  = dec_push_s && !filt_s;
    assign wr_en_s = push_s && (!full_s || pop_s);

    // FIFO next state; head is precomputed so outputs come straight from flops
    always_comb begin
        mem_d      = mem_q;
        overflow_d = overflow_q | (push_s && full_s && !pop_s);
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = {dec_ext_s, dec_brk_s, byte_in};
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d    = wr_en_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(wr_en_s) - CNT_W'(pop_s);
        key_valid_d = (count_d != CNT_W'(0));
        if (key_valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = 10'h000;
        end
    end

    // State, FIFO and output registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            seq_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            key_valid_q <= 1'b0;
            head_q      <= 10'h000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'h000;
        end else begin
            state_q     <= state_d;
            seq_err_q   <= seq_err_d;
            overflow_q  <= overflow_d;
            key_valid_q <= key_valid_d;
            head_q      <= head_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign key_code   = head_q[7:0];
    assign key_break  = head_q[8];
    assign key_ext    = head_q[9];
    assign key_valid  = key_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign seq_err    = seq_err_q;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_ps2_key_sequencer;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, overflow, seq_err;
    logic [2:0] fifo_count;
    logic [13:0] obs;

    int tests = 0;
    int fails = 0;

    ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .key_valid(key_valid), .key_ready(key_ready), .fifo_count(fifo_count),
        .overflow(overflow), .seq_err(seq_err)
    );

    always #5 CLK = ~CLK;

    // {valid, ext, brk, code, count}
    assign obs = {key_valid, key_ext, key_break, key_code, fifo_count};

    task automatic do_reset();
        reset = 1'b0; byte_valid = 1'b0; key_ready = 1'b0; byte_in = 8'h00;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        @(negedge CLK);
        byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        @(negedge CLK);
        key_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        send(8'h1C); send(8'hF0); send(8'hF0);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({obs, overflow, seq_err} !== 16'h0) begin
            fails++; $display("FAIL reset_async: got %h expected 0000", {obs, overflow, seq_err});
        end
        byte_in = 8'h1C; byte_valid = 1'b1;
        repeat (2) @(negedge CLK);
        tests++;
        if (obs !== 14'h0) begin
            fails++; $display("FAIL reset_hold_no_push: got %h expected 0000", obs);
        end
        byte_valid = 1'b0; reset = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_make();
        do_reset();
        send(8'h1C);
        tests++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h1C, 3'd1}) begin
            fails++; $display("FAIL single_make: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 8'h1C, 3'd1});
        end
    endtask

    task automatic test_ext_break();
        do_reset();
        send(8'hE0); send(8'hF0); send(8'h75);
        tests++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h75, 3'd1}) begin
            fails++; $display("FAIL ext_break: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 8'h75, 3'd1});
        end
        pop_one();
        send(8'hF0); send(8'h1C);
        tests++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h1C, 3'd1}) begin
            fails++; $display("FAIL break: got %h expected %h", obs, {1'b1, 1'b0, 1'b1, 8'h1C, 3'd1});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        for (int i = 0; i < 5; i++) send(codes[i]);
        tests++;
        if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
            fails++; $display("FAIL overflow_fill: got cnt=%0d ovf=%b expected cnt=4 ovf=1", fifo_count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({key_valid, key_code} !== {1'b1, codes[i]}) begin
                fails++; $display("FAIL overflow_order[%0d]: got %h expected %h", i, {key_valid, key_code}, {1'b1, codes[i]});
            end
            pop_one();
        end
        pop_one();
        tests++;
        if ({key_valid, fifo_count, overflow} !== {1'b0, 3'd0, 1'b1}) begin
            fails++; $display("FAIL overflow_drain: got %h expected %h", {key_valid, fifo_count, overflow}, {1'b0, 3'd0, 1'b1});
        end
    endtask

    task automatic test_seq_err();
        do_reset();
        send(8'hF0); send(8'hF0);
        tests++;
        if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_err_ff: got %b expected 1", seq_err); end
        @(negedge CLK);
        tests++;
        if ({seq_err, obs} !== 15'h0) begin
            fails++; $display("FAIL seq_err_ff_width: got %h expected 0", {seq_err, obs});
        end
        send(8'h00);
        tests++;
        if (seq_err !== 1'b1) begin fails++; $display("FAIL seq_err_00: got %b expected 1", seq_err); end
        send(8'h1C);
        tests++;
        if ({seq_err, obs} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 3'd1}) begin
            fails++; $display("FAIL seq_err_recover: got %h expected %h", {seq_err, obs}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 3'd1});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hE0);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        send(8'h6B);
        tests++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h6B, 3'd1}) begin
            fails++; $display("FAIL reset_mid_prefix: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 8'h6B, 3'd1});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        for (int i = 0; i < 4; i++) send(codes[i]);
        key_ready = 1'b1;
        send(codes[4]);
        key_ready = 1'b0;
        tests++;
        if ({fifo_count, overflow, key_code} !== {3'd4, 1'b0, 8'h1D}) begin
            fails++; $display("FAIL full_push_pop: got %h expected %h", {fifo_count, overflow, key_code}, {3'd4, 1'b0, 8'h1D});
        end
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (key_code !== codes[i]) begin
                fails++; $display("FAIL full_push_pop_order[%0d]: got %h expected %h", i, key_code, codes[i]);
            end
            pop_one();
        end
        do_reset();
        send(8'h15);
        key_ready = 1'b1;
        send(8'h1D);
        key_ready = 1'b0;
        tests++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h1D, 3'd1}) begin
            fails++; $display("FAIL count1_push_pop: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 8'h1D, 3'd1});
        end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [6];
        logic [9:0] got [$];
        logic [9:0] exp [$];
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp = '{10'h01C, 10'h11C, 10'h01C};
`else
        exp = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        do_reset();
        key_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) send(seq[i]);
            else @(negedge CLK);
            if (key_valid) got.push_back({key_ext, key_break, key_code});
        end
        key_ready = 1'b0;
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL typematic: got %0d events expected %0d", got.size(), exp.size());
        end
    endtask

    task automatic test_random();
        logic [9:0] mq [$];
        logic [8:0] rec;
        bit         m_ext, m_brk, m_ovf, m_err, rec_v, pop, push, isbrk;
        logic [7:0] b;
        logic [9:0] ev;
        do_reset();
        mq = {}; m_ext = 0; m_brk = 0; m_ovf = 0; rec_v = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 499) begin
                do_reset();
                mq = {}; m_ext = 0; m_brk = 0; m_ovf = 0; rec_v = 0;
            end
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: b = 8'h10 + 8'($urandom_range(0, 3));
            endcase
            byte_in    = b;
            byte_valid = ($urandom_range(0, 9) < 6);
            key_ready  = ($urandom_range(0, 9) < 3);
            pop = (mq.size() != 0) && key_ready;
            push = 0; m_err = 0; isbrk = 0; ev = 10'h0;
            if (byte_valid) begin
                if (b == 8'h00 || b == 8'hFF) begin
                    m_err = 1; m_ext = 0; m_brk = 0;
                end else if (b == 8'hE0 || b == 8'hF0) begin
                    if (m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
                    else if (b == 8'hE0) m_ext = 1;
                    else m_brk = 1;
                end else begin
                    push = 1; isbrk = m_brk; ev = {m_ext, m_brk, b};
                    m_ext = 0; m_brk = 0;
                end
            end
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (push && rec_v && rec == {ev[9], ev[7:0]}) begin
                if (isbrk) rec_v = 0;
                else push = 0;
            end
`endif
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(ev);
                    if (!isbrk) begin rec_v = 1; rec = {ev[9], ev[7:0]}; end
                end else begin
                    m_ovf = 1;
                end
            end
            @(negedge CLK);
            byte_valid = 1'b0;
            tests++;
            if ({key_valid, fifo_count, overflow, seq_err} !== {mq.size() != 0, 3'(mq.size()), m_ovf, m_err}) begin
                fails++;
                $display("FAIL rand_status cyc=%0d: got v=%b cnt=%0d ovf=%b err=%b expected v=%b cnt=%0d ovf=%b err=%b",
                         cyc, key_valid, fifo_count, overflow, seq_err, mq.size() != 0, mq.size(), m_ovf, m_err);
            end
            if (mq.size() != 0) begin
                tests++;
                if ({key_ext, key_break, key_code} !== mq[0]) begin
                    fails++; $display("FAIL rand_head cyc=%0d: got %h expected %h", cyc, {key_ext, key_break, key_code}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_ext_break();
        test_overflow();
        test_seq_err();
        test_reset_mid();
        test_back_to_back();
        test_typematic();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
